// File: rtl/fpu_scoreboard_hazard_unit.sv
// Hazard unit for the 5-stage core: integer forwarding/stalls plus a per-register
// FPU scoreboard with a writeback-slot reservation table for pipelined FPU ops.

module fpu_sb_cnt #(
  parameter int LATW = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            load,
  input  logic [LATW-1:0] load_val,
  output logic [LATW-1:0] cnt
);
  logic [LATW-1:0] cnt_d, cnt_q;

  // A new issue overrides a pending writeback on the same register.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    if (load)        cnt_d = load_val;
  end

  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

module fpu_scoreboard_hazard_unit #(
  parameter int REGW      = 6,
  parameter int LATW      = 4,
  parameter int LAT_FADD  = 3,
  parameter int LAT_FSUB  = 3,
  parameter int LAT_FMUL  = 2,
  parameter int LAT_FDIV  = 5,
  parameter int LAT_FSQRT = 2,
  parameter int LAT_CVT   = 1,
  parameter int MAXLAT    = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_ready,
  input  logic              in_d,
  input  logic              branch_d,
  input  logic              regtopc_d,
  input  logic [REGW-1:0]   rs_d,
  input  logic [REGW-1:0]   rt_d,
  input  logic [REGW-1:0]   wreg_d,
  input  logic              regwrite_d,
  input  logic              fpu_issue_d,
  input  logic [4:0]        fpu_op_d,
  input  logic [REGW-1:0]   rs_e,
  input  logic [REGW-1:0]   rt_e,
  input  logic [REGW-1:0]   wreg_e,
  input  logic              regwrite_e,
  input  logic              memtoreg_e,
  input  logic              fpu_issue_e,
  input  logic [4:0]        fpu_op_e,
  input  logic [REGW-1:0]   wreg_m,
  input  logic [REGW-1:0]   wreg_w,
  input  logic              regwrite_m,
  input  logic              memtoreg_m,
  input  logic              regwrite_w,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_e,
  output logic              fwd_a_d,
  output logic              fwd_b_d,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              fpu_wb_valid,
  output logic [REGW-1:0]   fpu_wb_reg,
  output logic [2**REGW-1:0] sb_busy
);
  localparam int NREG = 2**REGW;

  function automatic logic [LATW-1:0] op_lat(input logic [4:0] op);
    case (op)
      5'b00001:                   op_lat = LATW'(LAT_FADD);
      5'b00011:                   op_lat = LATW'(LAT_FSUB);
      5'b00101:                   op_lat = LATW'(LAT_FMUL);
      5'b00111:                   op_lat = LATW'(LAT_FDIV);
      5'b01101:                   op_lat = LATW'(LAT_FSQRT);
      5'b10001, 5'b10011, 5'b10101: op_lat = LATW'(LAT_CVT);
      default:                    op_lat = '0;
    endcase
  endfunction

  function automatic logic [1:0] fwd_sel_e(input logic [REGW-1:0] src,
                                           input logic [REGW-1:0] wm, input logic rwm,
                                           input logic [REGW-1:0] ww, input logic rww);
    if (src != '0 && src == wm && rwm)      fwd_sel_e = 2'b10;
    else if (src != '0 && src == ww && rww) fwd_sel_e = 2'b01;
    else                                    fwd_sel_e = 2'b00;
  endfunction

  logic [LATW-1:0]            lat_e, lat_d;
  logic                       issue_e;
  logic [NREG-1:0][LATW-1:0]  cnt;
  logic [MAXLAT:1]            slot_d, slot_q;
  logic                       rdy_d, rdy_q;

  assign lat_e   = op_lat(fpu_op_e);
  assign lat_d   = op_lat(fpu_op_d);
  assign issue_e = fpu_issue_e && (lat_e != '0);

  // Register 0 is never tracked; its counter is tied off.
  assign cnt[0] = '0;
  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    fpu_sb_cnt #(.LATW(LATW)) u_cnt (
      .clk      (clk),
      .rstn     (rstn),
      .load     (issue_e && (wreg_e == REGW'(r))),
      .load_val (lat_e),
      .cnt      (cnt[r])
    );
  end

  // slot_q[k] marks an FPU writeback k-1 cycles from now; slot_q[1] is this cycle.
  always_comb begin
    slot_d = '0;
    for (int k = 1; k < MAXLAT; k++) slot_d[k] = slot_q[k+1];
    if (issue_e)
      for (int k = 1; k <= MAXLAT; k++)
        if (int'(lat_e) == k) slot_d[k] = 1'b1;
  end

  assign rdy_d = 1'b1;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      slot_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      slot_q <= slot_d;
      rdy_q  <= rdy_d;
    end
  end

  logic out_en;
  assign out_en = rstn && rdy_q;

  logic raw_a, raw_b, raw_stall, waw_stall, port_stall, slot_hit;
  logic lw_stall, br_stall, jr_stall, in_stall, stall_any;

  assign raw_a = (rs_d != '0) &&
                 ((cnt[rs_d] >= LATW'(2)) || (issue_e && wreg_e == rs_d));
  assign raw_b = (rt_d != '0) &&
                 ((cnt[rt_d] >= LATW'(2)) || (issue_e && wreg_e == rt_d));
  assign raw_stall = raw_a || raw_b;

  // A counter at 1 writes back this cycle, so a later write to it is already ordered.
  assign waw_stall = (regwrite_d || fpu_issue_d) && (wreg_d != '0) &&
                     ((cnt[wreg_d] >= LATW'(2)) || (issue_e && wreg_e == wreg_d));

  // The D op would enter E next cycle and write back lat_d cycles after that.
  always_comb begin
    slot_hit = 1'b0;
    for (int k = 1; k <= MAXLAT; k++)
      if (int'(lat_d) + 2 == k) slot_hit = slot_q[k];
  end

  assign port_stall = fpu_issue_d && (lat_d != '0) &&
                      (slot_hit || (issue_e && int'(lat_e) == int'(lat_d) + 1));

  assign lw_stall = memtoreg_e && ((rs_d == rt_e) || (rt_d == rt_e));
  assign br_stall = branch_d &&
                    ((regwrite_e && (wreg_e == rs_d || wreg_e == rt_d)) ||
                     (memtoreg_m && (wreg_m == rs_d || wreg_m == rt_d)));
  assign jr_stall = regtopc_d &&
                    ((regwrite_e && rs_d == wreg_e) || (memtoreg_m && rs_d == wreg_m));
  assign in_stall = in_d && !rx_ready;

  assign stall_any = raw_stall || waw_stall || port_stall || lw_stall ||
                     br_stall || jr_stall || in_stall;

  logic              wb_v;
  logic [REGW-1:0]   wb_r;
  logic [NREG-1:0]   busy;

  always_comb begin
    wb_v = 1'b0;
    wb_r = '0;
    busy = '0;
    for (int r = NREG - 1; r >= 1; r--) begin
      busy[r] = (cnt[r] != '0);
      if (cnt[r] == LATW'(1)) begin
        wb_v = 1'b1;
        wb_r = REGW'(r);
      end
    end
  end

  assign stall_f      = out_en && stall_any;
  assign stall_d      = out_en && stall_any;
  assign flush_e      = out_en && stall_any;
  assign fwd_a_d      = out_en && (rs_d != '0) && (rs_d == wreg_m) && regwrite_m;
  assign fwd_b_d      = out_en && (rt_d != '0) && (rt_d == wreg_m) && regwrite_m;
  assign fwd_a_e      = out_en ? fwd_sel_e(rs_e, wreg_m, regwrite_m, wreg_w, regwrite_w) : 2'b00;
  assign fwd_b_e      = out_en ? fwd_sel_e(rt_e, wreg_m, regwrite_m, wreg_w, regwrite_w) : 2'b00;
  assign fpu_wb_valid = out_en && wb_v;
  assign fpu_wb_reg   = out_en ? wb_r : '0;
  assign sb_busy      = out_en ? busy : '0;
endmodule

// File: tb/tb_fpu_scoreboard_hazard_unit.sv
// Directed bench for fpu_scoreboard_hazard_unit: scoreboard timing, slot collisions,
// integer hazards, forwarding and reset behaviour.

module tb_fpu_scoreboard_hazard_unit;
  logic        clk, rstn, rx_ready, in_d, branch_d, regtopc_d;
  logic [5:0]  rs_d, rt_d, wreg_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w;
  logic        regwrite_d, fpu_issue_d, regwrite_e, memtoreg_e, fpu_issue_e;
  logic [4:0]  fpu_op_d, fpu_op_e;
  logic        regwrite_m, memtoreg_m, regwrite_w;
  logic        stall_f, stall_d, flush_e, fwd_a_d, fwd_b_d, fpu_wb_valid;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic [5:0]  fpu_wb_reg;
  logic [63:0] sb_busy;
  int checks = 0;
  int failures = 0;

  fpu_scoreboard_hazard_unit dut (
    .clk(clk), .rstn(rstn), .rx_ready(rx_ready), .in_d(in_d),
    .branch_d(branch_d), .regtopc_d(regtopc_d),
    .rs_d(rs_d), .rt_d(rt_d), .wreg_d(wreg_d), .regwrite_d(regwrite_d),
    .fpu_issue_d(fpu_issue_d), .fpu_op_d(fpu_op_d),
    .rs_e(rs_e), .rt_e(rt_e), .wreg_e(wreg_e), .regwrite_e(regwrite_e),
    .memtoreg_e(memtoreg_e), .fpu_issue_e(fpu_issue_e), .fpu_op_e(fpu_op_e),
    .wreg_m(wreg_m), .wreg_w(wreg_w), .regwrite_m(regwrite_m),
    .memtoreg_m(memtoreg_m), .regwrite_w(regwrite_w),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .fpu_wb_valid(fpu_wb_valid), .fpu_wb_reg(fpu_wb_reg), .sb_busy(sb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    rx_ready = 0; in_d = 0; branch_d = 0; regtopc_d = 0;
    rs_d = 0; rt_d = 0; wreg_d = 0; regwrite_d = 0; fpu_issue_d = 0; fpu_op_d = 0;
    rs_e = 0; rt_e = 0; wreg_e = 0; regwrite_e = 0; memtoreg_e = 0;
    fpu_issue_e = 0; fpu_op_e = 0;
    wreg_m = 0; wreg_w = 0; regwrite_m = 0; memtoreg_m = 0; regwrite_w = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 0; in_d = 1; rx_ready = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (stall_d !== 1'b0 || stall_f !== 1'b0) begin
        failures++; $display("FAIL reset_stall got=%b want=0", stall_d);
      end
      step();
    end
    rstn = 1;
    @(negedge clk);
    checks++;
    if (stall_d !== 1'b0) begin failures++; $display("FAIL reset_after_cycle got=%b want=0", stall_d); end
    checks++;
    if (sb_busy !== 64'd0) begin failures++; $display("FAIL reset_busy got=%h want=0", sb_busy); end
    step();
    @(negedge clk);
    checks++;
    if (stall_d !== 1'b1) begin failures++; $display("FAIL reset_release_stall got=%b want=1", stall_d); end
    step();
    idle_cycles(1);
  endtask

  task automatic test_fdiv_raw();
    idle_inputs();
    fpu_issue_e = 1; fpu_op_e = 5'b00111; wreg_e = 5;
    @(negedge clk);
    checks++;
    if (stall_d !== 1'b0) begin failures++; $display("FAIL fdiv_t0_stall got=%b want=0", stall_d); end
    step();
    idle_inputs(); rs_d = 5; rt_d = 3;
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      checks++;
      if (stall_d !== (t <= 4)) begin
        failures++; $display("FAIL fdiv_stall_t%0d got=%b want=%b", t, stall_d, (t <= 4));
      end
      checks++;
      if (fpu_wb_valid !== (t == 5)) begin
        failures++; $display("FAIL fdiv_wb_valid_t%0d got=%b want=%b", t, fpu_wb_valid, (t == 5));
      end
      if (t == 5) begin
        checks++;
        if (fpu_wb_reg !== 6'd5) begin failures++; $display("FAIL fdiv_wb_reg got=%0d want=5", fpu_wb_reg); end
      end
      checks++;
      if (sb_busy[5] !== 1'b1) begin failures++; $display("FAIL fdiv_busy_t%0d got=%b want=1", t, sb_busy[5]); end
      step();
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (sb_busy !== 64'd0 || fpu_wb_valid !== 1'b0) begin
      failures++; $display("FAIL fdiv_done got busy=%h wb=%b want 0/0", sb_busy, fpu_wb_valid);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_stall, exp_wb;
    logic [5:0] exp_reg [7];
    exp_stall = 7'b0001001;   // bit t
    exp_wb    = 7'b1011000;
    exp_reg   = '{0, 0, 0, 3, 4, 0, 6};
    for (int t = 0; t <= 6; t++) begin
      idle_inputs();
      case (t)
        0: begin fpu_issue_e = 1; fpu_op_e = 5'b00001; wreg_e = 3;
                 fpu_issue_d = 1; fpu_op_d = 5'b00101; wreg_d = 4; rs_d = 1; rt_d = 2; end
        1: begin fpu_issue_d = 1; fpu_op_d = 5'b00101; wreg_d = 4; rs_d = 1; rt_d = 2; end
        2: begin fpu_issue_e = 1; fpu_op_e = 5'b00101; wreg_e = 4;
                 fpu_issue_d = 1; fpu_op_d = 5'b00001; wreg_d = 6; rs_d = 1; rt_d = 2; end
        3: begin fpu_issue_e = 1; fpu_op_e = 5'b00001; wreg_e = 6; rs_d = 6; end
        default: ;
      endcase
      @(negedge clk);
      checks++;
      if (stall_d !== exp_stall[t]) begin
        failures++; $display("FAIL b2b_stall_t%0d got=%b want=%b", t, stall_d, exp_stall[t]);
      end
      checks++;
      if (fpu_wb_valid !== exp_wb[t]) begin
        failures++; $display("FAIL b2b_wb_valid_t%0d got=%b want=%b", t, fpu_wb_valid, exp_wb[t]);
      end
      if (exp_wb[t]) begin
        checks++;
        if (fpu_wb_reg !== exp_reg[t]) begin
          failures++; $display("FAIL b2b_wb_reg_t%0d got=%0d want=%0d", t, fpu_wb_reg, exp_reg[t]);
        end
      end
      step();
    end
    idle_cycles(2);
  endtask

  task automatic test_port_slot();
    logic [8:0] exp_stall, exp_wb;
    exp_stall = 9'b000000010;
    exp_wb    = 9'b001100000;   // r10 at t5, r11 at t6
    for (int t = 0; t <= 8; t++) begin
      idle_inputs();
      case (t)
        0: begin fpu_issue_e = 1; fpu_op_e = 5'b00111; wreg_e = 10; end
        1, 2: begin fpu_issue_d = 1; fpu_op_d = 5'b00001; wreg_d = 11; rs_d = 1; rt_d = 2; end
        3: begin fpu_issue_e = 1; fpu_op_e = 5'b00001; wreg_e = 11; end
        default: ;
      endcase
      @(negedge clk);
      checks++;
      if (stall_d !== exp_stall[t]) begin
        failures++; $display("FAIL port_stall_t%0d got=%b want=%b", t, stall_d, exp_stall[t]);
      end
      checks++;
      if (fpu_wb_valid !== exp_wb[t]) begin
        failures++; $display("FAIL port_wb_valid_t%0d got=%b want=%b", t, fpu_wb_valid, exp_wb[t]);
      end
      if (exp_wb[t]) begin
        checks++;
        if (fpu_wb_reg !== ((t == 5) ? 6'd10 : 6'd11)) begin
          failures++; $display("FAIL port_wb_reg_t%0d got=%0d want=%0d", t, fpu_wb_reg, (t == 5) ? 10 : 11);
        end
      end
      step();
    end
  endtask

  task automatic test_waw();
    idle_inputs();
    fpu_issue_e = 1; fpu_op_e = 5'b01101; wreg_e = 7;
    step();
    idle_inputs(); regwrite_d = 1; wreg_d = 7; rs_d = 1; rt_d = 1;
    @(negedge clk);
    checks++;
    if (stall_d !== 1'b1) begin failures++; $display("FAIL waw_cnt2_stall got=%b want=1", stall_d); end
    checks++;
    if (sb_busy[7] !== 1'b1) begin failures++; $display("FAIL waw_busy got=%b want=1", sb_busy[7]); end
    step();
    @(negedge clk);
    checks++;
    if (stall_d !== 1'b0) begin failures++; $display("FAIL waw_cnt1_stall got=%b want=0", stall_d); end
    checks++;
    if (fpu_wb_valid !== 1'b1 || fpu_wb_reg !== 6'd7) begin
      failures++; $display("FAIL waw_wb got=%b/%0d want=1/7", fpu_wb_valid, fpu_wb_reg);
    end
    step();
    idle_cycles(1);
  endtask

  task automatic test_load_use();
    idle_inputs();
    memtoreg_e = 1; regwrite_e = 1; rt_e = 2; wreg_e = 2; rs_d = 2; rt_d = 2;
    @(negedge clk);
    checks++;
    if ({stall_f, stall_d, flush_e} !== 3'b111) begin
      failures++; $display("FAIL lw_stall got=%b want=111", {stall_f, stall_d, flush_e});
    end
    step();
    idle_inputs();
    memtoreg_m = 1; regwrite_m = 1; wreg_m = 2; rs_d = 2; rt_d = 4;
    @(negedge clk);
    checks++;
    if ({stall_d, fwd_a_d, fwd_b_d} !== 3'b010) begin
      failures++; $display("FAIL lw_release_fwd_d got=%b want=010", {stall_d, fwd_a_d, fwd_b_d});
    end
    step();
    idle_inputs();
    regwrite_w = 1; wreg_w = 2; regwrite_m = 1; wreg_m = 9; rs_e = 2; rt_e = 2;
    @(negedge clk);
    checks++;
    if ({fwd_a_e, fwd_b_e} !== 4'b0101) begin
      failures++; $display("FAIL fwd_w got=%b want=0101", {fwd_a_e, fwd_b_e});
    end
    wreg_m = 2; rt_e = 3;
    @(negedge clk);
    checks++;
    if ({fwd_a_e, fwd_b_e} !== 4'b1000) begin
      failures++; $display("FAIL fwd_m_priority got=%b want=1000", {fwd_a_e, fwd_b_e});
    end
    step();
  endtask

  task automatic test_branch_jr();
    idle_inputs();
    branch_d = 1; rs_d = 4; rt_d = 1; regwrite_e = 1; wreg_e = 4;
    @(negedge clk);
    checks++;
    if (stall_d !== 1'b1) begin failures++; $display("FAIL branch_e_stall got=%b want=1", stall_d); end
    wreg_e = 12;
    @(negedge clk);
    checks++;
    if (stall_d !== 1'b0) begin failures++; $display("FAIL branch_nodep got=%b want=0", stall_d); end
    step();
    idle_inputs();
    regtopc_d = 1; rs_d = 8; memtoreg_m = 1; wreg_m = 8;
    @(negedge clk);
    checks++;
    if (stall_d !== 1'b1) begin failures++; $display("FAIL jr_m_stall got=%b want=1", stall_d); end
    step();
  endtask

  task automatic test_input_stall();
    idle_inputs();
    in_d = 1;
    for (int t = 0; t < 5; t++) begin
      rx_ready = (t == 4);
      @(negedge clk);
      checks++;
      if ({stall_f, stall_d} !== {2{t < 4}}) begin
        failures++; $display("FAIL in_stall_t%0d got=%b want=%b", t, {stall_f, stall_d}, {2{t < 4}});
      end
      step();
    end
    idle_cycles(1);
  endtask

  task automatic test_reset_midop();
    idle_inputs();
    fpu_issue_e = 1; fpu_op_e = 5'b00111; wreg_e = 9;
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (sb_busy[9] !== 1'b1) begin failures++; $display("FAIL midop_busy_t1 got=%b want=1", sb_busy[9]); end
    step();
    rstn = 0;
    for (int t = 2; t <= 10; t++) begin
      if (t == 3) rstn = 1;
      @(negedge clk);
      checks++;
      if (fpu_wb_valid !== 1'b0 || sb_busy !== 64'd0) begin
        failures++; $display("FAIL midop_t%0d got wb=%b busy=%h want 0/0", t, fpu_wb_valid, sb_busy);
      end
      step();
    end
  endtask

  initial begin
    rstn = 0;
    idle_inputs();
    test_reset();
    test_fdiv_raw();
    test_back_to_back();
    idle_cycles(2);
    test_port_slot();
    idle_cycles(2);
    test_waw();
    test_load_use();
    test_branch_jr();
    test_input_stall();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
